alu_share_arb: RTL and testbench
================================

# alu_share_arb

Arbiter and sequencer that shares the single 8-bit ALU between two requesters: port 0 (execute stage) and port 1 (auxiliary unit, e.g. interrupt/loop helper). It owns the architectural condition-code register (CCR: V,C,N,Z = bits 3..0) that feeds the ALU's old-flags input, and commits new flags on accepted operations. It also registers the result back to the winning requester. It sits between the execute-stage operand muxes and the ALU instance.

## Interface
- No parameters; all widths are fixed: data 8, op 4, shift type 2, flags 4.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  (N=0,1) request present
- reqN_ready  out  1  request accepted this cycle (combinational grant)
- reqN_a, reqN_b  in  8  operands
- reqN_op  in  4  ALU opcode
- reqN_shift  in  2  shift/unary sub-select
- reqN_flag_we  in  1  commit ALU flags to CCR on acceptance
- req0_lock  in  1  hold grant on port 0 (only with lock feature)
- alu_a, alu_b  out  8  driven from granted port, else 0
- alu_op  out  4  granted op, else 4'b0000
- alu_shift  out  2  granted shift select, else 0
- alu_old_flags  out  4  always equals flags_q
- alu_result  in  8  ALU result (combinational)
- alu_new_flags  in  4  ALU flags (combinational)
- rspN_valid  out  1  one-cycle pulse, result for port N
- rspN_result  out  8  registered result
- rspN_flags  out  4  registered alu_new_flags of that op
- flags_q  out  4  CCR
- flags_load  in  1  restore CCR (interrupt return)
- flags_load_val  in  4  value to restore

## Operation
- At most one operation per cycle; accept = reqN_valid & reqN_ready.
- Round-robin: rr_ptr names the preferred port. If only one port is valid, it wins. If both are valid, the rr_ptr port wins. After any acceptance, rr_ptr points to the other port.
- Both reqN_ready are 0 when no request is valid. Ready never asserts without the matching valid.
- FSM (lock feature only):
  - ARB → LOCKED on a port-0 acceptance with req0_lock=1.
  - In LOCKED, only port 0 may be granted, and req1_ready=0.
  - LOCKED → ARB on the first cycle where req0_lock=0. That cycle already arbitrates normally.
  - While LOCKED, rr_ptr is frozen at 1, so port 1 wins the first contested cycle after unlock.
- CCR update priority, highest first:
  1. flags_load → flags_q ← flags_load_val, regardless of any accepted op.
  2. accepted op with flag_we=1 → flags_q ← alu_new_flags.
  3. Otherwise hold.
- The ALU reads flags_q directly, so back-to-back flag-dependent ops (e.g. ADD then RLC) see the committed carry with no bubble.
- A request may change its fields while not accepted. Fields are sampled only at the accept edge.

## Timing
- Grant and ALU drive are combinational in the accept cycle.
- Response latency is 1 cycle: rspN_valid=1 on the edge after acceptance, for exactly one cycle.
- There is no response backpressure. The requester must take the response.
- rspN_result and rspN_flags hold their last value until the next response for that port.
- Reset (asynchronous, any time, including mid-lock):
  - flags_q=0, rr_ptr=0, state=ARB.
  - rsp0_valid=rsp1_valid=0; rsp results and flags=0.
  - reqN_ready are combinational and reflect inputs once rst_n=1. While rst_n=0, both are forced to 0.
- An op accepted in the cycle reset asserts is discarded. No response and no flag commit.

## Configuration
- ALU_ARB_LOCK_EN defined: req0_lock and the ARB/LOCKED FSM are active as described.
- ALU_ARB_LOCK_EN undefined: req0_lock is ignored, no FSM state exists, and the block is pure round-robin.

## Test plan
- Reset: hold rst_n=0 with both valids high → readies 0, flags_q=0, no rsp. Release → port 0 granted first (rr_ptr=0).
- Contention: both valid for 4 cycles, port 0 ADD 0x7F+0x01 (flag_we=1), port 1 OR → grants alternate 0,1,0,1. Port 0 rsp: result 0x80, flags V=1,N=1,C=0,Z=0 (4'b1010); flags_q matches after its accept.
- Carry chain: port 0 SUB 0x00-0x01 (flag_we=1), then RLC B=0x40 in the next cycle → first result 0xFF, C=1; RLC result 0x81, C=0. No bubble between them.
- Restore collision: flags_load=1, flags_load_val=4'b0101, in the same cycle as an accepted flag_we op → flags_q=4'b0101. The rsp still carries that op's ALU flags.
- Lock (ALU_ARB_LOCK_EN): port 0 locked for 3 ops with port 1 valid throughout → req1_ready=0 for 3 cycles. The cycle lock drops, port 1 wins if both are valid.
- Async reset mid-lock: assert rst_n=0 between clock edges → state ARB, rsp valids drop immediately, flags_q=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters; owns the CCR.
// Optional port-0 grant lock (ARB/LOCKED FSM) enabled by `define ALU_ARB_LOCK_EN.
module alu_share_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic [1:0] req0_shift,
  input  logic       req0_flag_we,
  input  logic       req0_lock,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  input  logic [1:0] req1_shift,
  input  logic       req1_flag_we,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic [1:0] alu_shift,
  output logic [3:0] alu_old_flags,
  input  logic [7:0] alu_result,
  input  logic [3:0] alu_new_flags,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_result,
  output logic [3:0] rsp0_flags,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_result,
  output logic [3:0] rsp1_flags,
  output logic [3:0] flags_q,
  input  logic       flags_load,
  input  logic [3:0] flags_load_val
);

  logic       rr_q, rr_d;
  logic [3:0] flags_d;
  logic       rsp0_valid_q, rsp1_valid_q;
  logic [7:0] rsp0_result_q, rsp1_result_q;
  logic [3:0] rsp0_flags_q, rsp1_flags_q;
  logic       lock_hold;
  logic       acc0, acc1;

`ifdef ALU_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_e;
  state_e state_q, state_d;

  // Lock releases in the same cycle req0_lock drops.
  assign lock_hold = (state_q == LOCKED) & req0_lock;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:    if (acc0 && req0_lock) state_d = LOCKED;
      LOCKED: if (!req0_lock) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end
`else
  logic unused_lock;
  assign unused_lock = req0_lock;
  assign lock_hold   = 1'b0;
`endif

  assign req0_ready = rst_n & req0_valid
                    & (lock_hold | ~req1_valid | ~rr_q);
  assign req1_ready = rst_n & req1_valid & ~lock_hold
                    & (~req0_valid | rr_q);
  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  always_comb begin
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = 4'b0000;
    alu_shift = 2'b00;
    unique case (1'b1)
      acc0: begin
        alu_a     = req0_a;
        alu_b     = req0_b;
        alu_op    = req0_op;
        alu_shift = req0_shift;
      end
      acc1: begin
        alu_a     = req1_a;
        alu_b     = req1_b;
        alu_op    = req1_op;
        alu_shift = req1_shift;
      end
      default: ;
    endcase
  end

  assign alu_old_flags = flags_q;

  always_comb begin
    rr_d = rr_q;
    if (lock_hold) rr_d = 1'b1;
    else if (acc0) rr_d = 1'b1;
    else if (acc1) rr_d = 1'b0;
  end

  // Interrupt-return restore beats any flag commit in the same cycle.
  always_comb begin
    flags_d = flags_q;
    if (flags_load)
      flags_d = flags_load_val;
    else if ((acc0 & req0_flag_we) | (acc1 & req1_flag_we))
      flags_d = alu_new_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q          <= 1'b0;
      flags_q       <= 4'h0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= 8'h00;
      rsp1_result_q <= 8'h00;
      rsp0_flags_q  <= 4'h0;
      rsp1_flags_q  <= 4'h0;
    end else begin
      rr_q         <= rr_d;
      flags_q      <= flags_d;
      rsp0_valid_q <= acc0;
      rsp1_valid_q <= acc1;
      if (acc0) begin
        rsp0_result_q <= alu_result;
        rsp0_flags_q  <= alu_new_flags;
      end
      if (acc1) begin
        rsp1_result_q <= alu_result;
        rsp1_flags_q  <= alu_new_flags;
      end
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp0_flags  = rsp0_flags_q;
  assign rsp1_flags  = rsp1_flags_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed table-driven bench for alu_share_arb with a small reference ALU.
// Lock expectations follow ALU_ARB_LOCK_EN when it is defined.
module tb_alu_share_arb;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] OR  = 4'd2;
  localparam logic [3:0] RLC = 4'd3;

`ifdef ALU_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 0, req0_flag_we = 0, req0_lock = 0;
  logic req1_valid = 0, req1_flag_we = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic [1:0] req0_shift = 0, req1_shift = 0;
  logic flags_load = 0;
  logic [3:0] flags_load_val = 0;
  logic req0_ready, req1_ready;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op, alu_old_flags, alu_new_flags;
  logic [1:0] alu_shift;
  logic rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_result, rsp1_result;
  logic [3:0] rsp0_flags, rsp1_flags, flags_q;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_shift(req0_shift), .req0_flag_we(req0_flag_we),
    .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_shift(req1_shift), .req1_flag_we(req1_flag_we),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_shift(alu_shift), .alu_old_flags(alu_old_flags),
    .alu_result(alu_result), .alu_new_flags(alu_new_flags),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
    .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .rsp1_flags(rsp1_flags),
    .flags_q(flags_q), .flags_load(flags_load),
    .flags_load_val(flags_load_val)
  );

  // Reference ALU; flags are {V,C,N,Z}.
  always_comb begin
    logic [8:0] s;
    logic v, c;
    s = 9'h0;
    v = 1'b0;
    c = 1'b0;
    case (alu_op)
      ADD: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        c = s[8];
        v = (alu_a[7] == alu_b[7]) && (s[7] != alu_a[7]);
      end
      SUB: begin
        s = {1'b0, alu_a} - {1'b0, alu_b};
        c = s[8];
        v = (alu_a[7] != alu_b[7]) && (s[7] != alu_a[7]);
      end
      OR:  s = {1'b0, alu_a | alu_b};
      RLC: begin
        s = {1'b0, alu_b[6:0], alu_old_flags[2]};
        c = alu_b[7];
      end
      default: s = 9'h0;
    endcase
    alu_result    = s[7:0];
    alu_new_flags = {v, c, s[7], s[7:0] == 8'h00};
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic v0, v1;
    logic [3:0] op0; logic [7:0] a0, b0; logic we0;
    logic [3:0] op1; logic [7:0] a1, b1; logic we1;
    logic fl; logic [3:0] flv;
    logic r0, r1;
    logic [7:0] res; logic [3:0] rf; logic [3:0] fq;
  } vec_t;

  vec_t tbl[11];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_lock = 0; flags_load = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input string nm, input logic v0, input logic v1,
                     input logic lk, input logic e0, input logic e1);
    @(negedge clk);
    req0_valid = v0; req1_valid = v1; req0_lock = lk;
    req0_op = ADD; req0_a = 8'h7F; req0_b = 8'h01; req0_flag_we = 1;
    req1_op = OR;  req1_a = 8'h0F; req1_b = 8'hF0; req1_flag_we = 0;
    flags_load = 0;
    #1;
    chk({nm, ".rdy0"}, req0_ready, e0);
    chk({nm, ".rdy1"}, req1_ready, e1);
    @(posedge clk);
    #1;
    chk({nm, ".rsp0v"}, rsp0_valid, e0);
    chk({nm, ".rsp1v"}, rsp1_valid, e1);
  endtask

  initial begin
    tbl[0]  = '{1,1, ADD,8'h7F,8'h01,1, OR,8'h0F,8'hF0,0, 0,4'h0,
                1,0, 8'h80,4'b1010,4'b1010};
    tbl[1]  = '{1,1, ADD,8'h7F,8'h01,1, OR,8'h0F,8'hF0,0, 0,4'h0,
                0,1, 8'hFF,4'b0010,4'b1010};
    tbl[2]  = '{1,1, ADD,8'h7F,8'h01,1, OR,8'h0F,8'hF0,0, 0,4'h0,
                1,0, 8'h80,4'b1010,4'b1010};
    tbl[3]  = '{1,1, ADD,8'h7F,8'h01,1, OR,8'h0F,8'hF0,0, 0,4'h0,
                0,1, 8'hFF,4'b0010,4'b1010};
    tbl[4]  = '{1,0, SUB,8'h00,8'h01,1, OR,8'h00,8'h00,0, 0,4'h0,
                1,0, 8'hFF,4'b0110,4'b0110};
    tbl[5]  = '{1,0, RLC,8'h00,8'h40,1, OR,8'h00,8'h00,0, 0,4'h0,
                1,0, 8'h81,4'b0010,4'b0010};
    tbl[6]  = '{1,0, ADD,8'h7F,8'h01,1, OR,8'h00,8'h00,0, 1,4'b0101,
                1,0, 8'h80,4'b1010,4'b0101};
    tbl[7]  = '{0,0, ADD,8'h00,8'h00,0, OR,8'h00,8'h00,0, 0,4'h0,
                0,0, 8'h00,4'h0,4'b0101};
    tbl[8]  = '{0,1, ADD,8'h00,8'h00,0, OR,8'h00,8'h00,0, 0,4'h0,
                0,1, 8'h00,4'b0001,4'b0101};
    tbl[9]  = '{0,0, ADD,8'h00,8'h00,0, OR,8'h00,8'h00,0, 1,4'b1111,
                0,0, 8'h00,4'h0,4'b1111};
    tbl[10] = '{0,1, ADD,8'h00,8'h00,0, ADD,8'h01,8'h01,1, 0,4'h0,
                0,1, 8'h02,4'b0000,4'b0000};

    // Reset held with both requesters valid.
    req0_valid = 1; req1_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy0", req0_ready, 0);
    chk("rst.rdy1", req1_ready, 0);
    chk("rst.flags", flags_q, 0);
    chk("rst.rsp0v", rsp0_valid, 0);
    chk("rst.rsp1v", rsp1_valid, 0);
    req0_valid = 0; req1_valid = 0;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_op = tbl[i].op0; req0_a = tbl[i].a0; req0_b = tbl[i].b0;
      req0_flag_we = tbl[i].we0;
      req1_op = tbl[i].op1; req1_a = tbl[i].a1; req1_b = tbl[i].b1;
      req1_flag_we = tbl[i].we1;
      flags_load = tbl[i].fl; flags_load_val = tbl[i].flv;
      #1;
      chk($sformatf("v%0d.rdy0", i), req0_ready, tbl[i].r0);
      chk($sformatf("v%0d.rdy1", i), req1_ready, tbl[i].r1);
      chk($sformatf("v%0d.alu_a", i), alu_a,
          tbl[i].r0 ? tbl[i].a0 : (tbl[i].r1 ? tbl[i].a1 : 8'h00));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.rsp0v", i), rsp0_valid, tbl[i].r0);
      chk($sformatf("v%0d.rsp1v", i), rsp1_valid, tbl[i].r1);
      if (tbl[i].r0) begin
        chk($sformatf("v%0d.res0", i), rsp0_result, tbl[i].res);
        chk($sformatf("v%0d.rf0", i), rsp0_flags, tbl[i].rf);
      end
      if (tbl[i].r1) begin
        chk($sformatf("v%0d.res1", i), rsp1_result, tbl[i].res);
        chk($sformatf("v%0d.rf1", i), rsp1_flags, tbl[i].rf);
      end
      chk($sformatf("v%0d.ccr", i), flags_q, tbl[i].fq);
      chk($sformatf("v%0d.oldf", i), alu_old_flags, tbl[i].fq);
    end
    flags_load = 0;
    chk("hold.res0", rsp0_result, 8'h80);
    chk("hold.res1", rsp1_result, 8'h02);

    // Lock run: port 1 shut out while locked, wins on unlock.
    do_reset();
    cyc("lk1", 1, 1, 1, 1, 0);
    cyc("lk2", 1, 1, 1, LOCK, !LOCK);
    cyc("lk3", 1, 1, 1, 1, 0);
    cyc("lk4", 1, 1, 0, 0, 1);

    // Asynchronous reset between edges while locked.
    do_reset();
    cyc("mid", 1, 1, 1, 1, 0);
    chk("mid.ccr", flags_q, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.rsp0v", rsp0_valid, 0);
    chk("arst.res0", rsp0_result, 0);
    chk("arst.ccr", flags_q, 0);
    chk("arst.rdy0", req0_ready, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    rst_n = 1'b1;
    cyc("post1", 0, 1, 1, 0, 1);
    cyc("post2", 1, 1, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
